// File: rtl/core_pkg.sv
// core_pkg: shared types and opcode constants for the RV32-subset multi-cycle core.
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU_I = 3'd0,
    CL_ALU_R = 3'd1,
    CL_LUI   = 3'd2,
    CL_LOAD  = 3'd3,
    CL_STORE = 3'd4,
    CL_JALR  = 3'd5
  } op_class_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_t;

  typedef enum logic {
    PC_PLUS4 = 1'b0,
    PC_ALU   = 1'b1
  } pc_sel_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic      legal;
    op_class_t cls;
  } dec_t;

  function automatic dec_t classify(input logic [6:0] opc);
    dec_t d;
    d.legal = 1'b1;
    d.cls   = CL_ALU_I;
    case (opc)
      OPC_OP_IMM: d.cls = CL_ALU_I;
      OPC_OP:     d.cls = CL_ALU_R;
      OPC_LUI:    d.cls = CL_LUI;
      OPC_LOAD:   d.cls = CL_LOAD;
      OPC_STORE:  d.cls = CL_STORE;
      OPC_JALR:   d.cls = CL_JALR;
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wdog.sv
// mem_wdog: counts stalled memory-request cycles; flags the cycle that would reach MEM_TIMEOUT.
`default_nettype none

module mem_wdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_cnt,
  output logic o_at_limit
);

  generate
    if (MEM_TIMEOUT > 0) begin : g_wdog_on
      localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
      localparam logic [CW-1:0] C_LIMIT = CW'(MEM_TIMEOUT - 1);

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_cnt) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      // Registered compare: a stall in this cycle would be the MEM_TIMEOUT-th one.
      assign o_at_limit = (r_cnt == C_LIMIT);
    end else begin : g_wdog_off
      assign o_at_limit = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle fetch/decode/execute/memory/writeback sequencer with
// shared memory-port arbitration, sticky trap and retired-instruction counter.
`default_nettype none

module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             dec_wen,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_d,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             alu_src_imm,
  output logic             rf_wen,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic             trap,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  op_class_t        r_class;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_retired;

  dec_t             w_dec;
  wb_sel_t          w_wb_sel;
  pc_sel_t          w_pc_sel;
  logic             w_retire;
  logic             w_wd_trip;
  logic             w_at_limit;
  logic             w_is_mem_op;

  assign w_dec       = classify(opcode);
  assign w_is_mem_op = (r_class == CL_LOAD) || (r_class == CL_STORE);

  mem_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_next != r_state),
    .i_cnt     (mem_req && !mem_ready),
    .o_at_limit(w_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_class       <= CL_ALU_I;
      r_timeout_err <= 1'b0;
      r_retired     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_class <= w_dec.cls;
      end
      if (w_wd_trip) begin
        r_timeout_err <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel_d   = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    w_pc_sel    = PC_PLUS4;
    alu_src_imm = 1'b0;
    rf_wen      = 1'b0;
    w_wb_sel    = WB_ALU;
    w_retire    = 1'b0;
    w_wd_trip   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (run) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en  = 1'b1;
          w_next = ST_DECODE;
        end else if (w_at_limit) begin
          w_wd_trip = 1'b1;
          w_next    = ST_TRAP;
        end
      end
      ST_DECODE: begin
        w_next = w_dec.legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        alu_src_imm = (r_class != CL_ALU_R);
        w_next      = w_is_mem_op ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        // Operand select held so the ALU-computed address stays stable while stalled.
        alu_src_imm = 1'b1;
        mem_req     = 1'b1;
        mem_sel_d   = 1'b1;
        mem_we      = (r_class == CL_STORE);
        if (mem_ready) begin
          if (r_class == CL_STORE) begin
            pc_en    = 1'b1;
            w_retire = 1'b1;
            w_next   = run ? ST_FETCH : ST_IDLE;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_at_limit) begin
          w_wd_trip = 1'b1;
          w_next    = ST_TRAP;
        end
      end
      ST_WB: begin
        alu_src_imm = (r_class != CL_ALU_R);
        rf_wen      = dec_wen;
        pc_en       = 1'b1;
        w_retire    = 1'b1;
        case (r_class)
          CL_LOAD: w_wb_sel = WB_MEM;
          CL_JALR: w_wb_sel = WB_PC4;
          CL_LUI:  w_wb_sel = WB_IMM;
          default: w_wb_sel = WB_ALU;
        endcase
        w_pc_sel = (r_class == CL_JALR) ? PC_ALU : PC_PLUS4;
        w_next   = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        w_next = ST_TRAP;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign wb_sel      = w_wb_sel;
  assign pc_sel      = w_pc_sel;
  assign busy        = (r_state != ST_IDLE) && (r_state != ST_TRAP);
  assign trap        = (r_state == ST_TRAP);
  assign timeout_err = r_timeout_err;
  assign retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed bench with a retire scoreboard for core_seq_ctrl.
`default_nettype none

module tb_core_seq_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [6:0]  opcode;
  logic        dec_wen;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_sel_d, ir_en, pc_en, pc_sel, alu_src_imm, rf_wen;
  logic [1:0]  wb_sel;
  logic        busy, trap, timeout_err;
  logic [31:0] retired;

  int n_tot  = 0;
  int n_pass = 0;

  typedef struct {
    logic [1:0] wb;
    logic       rf;
    logic       pcs;
    logic       chk_wb;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  core_seq_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .dec_wen    (dec_wen),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_sel_d  (mem_sel_d),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .alu_src_imm(alu_src_imm),
    .rf_wen     (rf_wen),
    .wb_sel     (wb_sel),
    .busy       (busy),
    .trap       (trap),
    .timeout_err(timeout_err),
    .retired    (retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Retire monitor: every PC update must match the oldest outstanding instruction.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && pc_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ret_rf_wen", {31'd0, rf_wen}, {31'd0, e.rf});
        chk("ret_pc_sel", {31'd0, pc_sel}, {31'd0, e.pcs});
        if (e.chk_wb) chk("ret_wb_sel", {30'd0, wb_sel}, {30'd0, e.wb});
      end
    end
  end

  // Entered with the DUT in FETCH; returns one cycle after the retiring cycle.
  task automatic do_instr(input logic [6:0] op, input logic wen, input int fwait,
                          input int mwait, input logic stop);
    exp_t e;
    logic is_ld, is_st;
    is_ld = (op == OPC_LOAD);
    is_st = (op == OPC_STORE);
    opcode  = op;
    dec_wen = wen;
    e.rf     = is_st ? 1'b0 : wen;
    e.pcs    = (op == OPC_JALR);
    e.chk_wb = !is_st;
    e.wb     = is_ld ? 2'b01 : (op == OPC_JALR) ? 2'b10 : (op == OPC_LUI) ? 2'b11 : 2'b00;
    sb.push_back(e);

    for (int i = 0; i < fwait; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("fetch_wait_req", {31'd0, mem_req}, 32'd1);
      chk("fetch_wait_ir", {31'd0, ir_en}, 32'd0);
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    chk("fetch_ir_en", {31'd0, ir_en}, 32'd1);
    chk("fetch_sel", {31'd0, mem_sel_d}, 32'd0);
    nxt();
    mem_ready = 1'b0;
    #1;
    chk("decode_req", {31'd0, mem_req}, 32'd0);
    nxt();
    #1;
    chk("exec_src_imm", {31'd0, alu_src_imm}, {31'd0, (op != OPC_OP)});
    if (stop) run = 1'b0;
    nxt();
    if (is_ld || is_st) begin
      for (int i = 0; i < mwait; i++) begin
        #1;
        chk("mem_wait_req", {31'd0, mem_req}, 32'd1);
        chk("mem_wait_sel", {31'd0, mem_sel_d}, 32'd1);
        chk("mem_wait_we", {31'd0, mem_we}, {31'd0, is_st});
        nxt();
      end
      mem_ready = 1'b1;
      #1;
      chk("mem_done_req", {31'd0, mem_req}, 32'd1);
      chk("mem_done_we", {31'd0, mem_we}, {31'd0, is_st});
      nxt();
      mem_ready = 1'b0;
    end
    if (!is_st) begin
      #1;
      chk("wb_pc_en", {31'd0, pc_en}, 32'd1);
      nxt();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int bad;
    rst_n = 1'b0; run = 1'b0; opcode = '0; dec_wen = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    rst_n = 1'b1;
    nxt();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    run = 1'b1;
    nxt();

    // ADDI, zero-wait memory: back in FETCH four cycles after the first
    do_instr(OPC_OP_IMM, 1'b1, 0, 0, 1'b0);
    #1;
    chk("addi_retired", retired, 32'd1);
    chk("addi_refetch", {31'd0, mem_req & ~mem_sel_d}, 32'd1);

    // LW then SW with three stall cycles on the data access
    do_instr(OPC_LOAD, 1'b1, 0, 3, 1'b0);
    do_instr(OPC_STORE, 1'b0, 0, 3, 1'b0);
    #1;
    chk("ldst_retired", retired, 32'd3);

    // JALR with run dropped in EXEC: completes then parks in IDLE
    do_instr(OPC_JALR, 1'b1, 0, 0, 1'b1);
    #1;
    chk("stop_busy", {31'd0, busy}, 32'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      if (mem_req !== 1'b0 || pc_en !== 1'b0) bad++;
      nxt();
    end
    chk("stop_no_fetch", bad, 0);
    chk("stop_retired", retired, 32'd4);
    mem_ready = 1'b0;
    run = 1'b1;
    nxt();

    // ADD uses rs2; LUI after one fetch stall
    do_instr(OPC_OP, 1'b1, 0, 0, 1'b0);
    do_instr(OPC_LUI, 1'b1, 1, 0, 1'b0);
    #1;
    chk("alu_retired", retired, 32'd6);

    // Asynchronous reset while a load is stalled in MEM
    opcode = OPC_LOAD; dec_wen = 1'b1; mem_ready = 1'b1;
    nxt();
    mem_ready = 1'b0;
    nxt();
    nxt();
    chk("abort_in_mem", {31'd0, mem_req & mem_sel_d}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_retired", retired, 32'd0);
    nxt();
    rst_n = 1'b1;
    nxt();
    do_instr(OPC_OP_IMM, 1'b1, 0, 0, 1'b0);
    #1;
    chk("restart_retired", retired, 32'd1);

    // Fetch watchdog: four stalled cycles with MEM_TIMEOUT=4
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_wait_req", {31'd0, mem_req}, 32'd1);
      nxt();
    end
    #1;
    chk("wd_trap", {31'd0, trap}, 32'd1);
    chk("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("wd_mem_req", {31'd0, mem_req}, 32'd0);
    chk("wd_busy", {31'd0, busy}, 32'd0);

    // Illegal opcode traps after DECODE and holds with run=1
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    chk("ill_rst_trap", {31'd0, trap}, 32'd0);
    chk("ill_rst_terr", {31'd0, timeout_err}, 32'd0);
    nxt();
    opcode = 7'h7F; mem_ready = 1'b1;
    #1;
    chk("ill_fetch", {31'd0, ir_en}, 32'd1);
    nxt();
    mem_ready = 1'b0;
    #1;
    chk("ill_decode_trap", {31'd0, trap}, 32'd0);
    nxt();
    #1;
    chk("ill_trap", {31'd0, trap}, 32'd1);
    chk("ill_terr", {31'd0, timeout_err}, 32'd0);
    chk("ill_busy", {31'd0, busy}, 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      mem_ready = i[0];
      #1;
      if (trap !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0 || ir_en !== 1'b0 ||
          pc_en !== 1'b0 || rf_wen !== 1'b0) bad++;
      nxt();
    end
    chk("ill_hold", bad, 0);
    chk("ill_retired", retired, 32'd0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
